// File: rtl/shift_reg_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_seq_pkg
//  Description : Shared definitions for the shift-register command sequencer:
//                downstream mode codes, FSM state encoding and the command
//                record layout at the default widths.
//  Revision    : 1.0  initial release
// ============================================================================
package shift_reg_seq_pkg;

    localparam int SR_WIDTH = 8;
    localparam int SR_CNT_W = 4;

    // shift_direction codes understood by the downstream shift register
    localparam logic [1:0] SR_SHL  = 2'b00;
    localparam logic [1:0] SR_INS  = 2'b01;
    localparam logic [1:0] SR_SHR  = 2'b10;
    localparam logic [1:0] SR_LOAD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [SR_WIDTH-1:0] data;
        logic                dir;
        logic [SR_CNT_W-1:0] count;
        logic                fill;
    } cmd_t;

endpackage
`default_nettype wire

// File: rtl/shift_reg_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_sequencer_if
//  Description : Command handshake bundle for shift_reg_sequencer.
//                master drives a command (valid + fields), slave returns ready.
//                A command transfers on a rising edge with valid && ready.
//  Revision    : 1.0  initial release
// ============================================================================
interface shift_reg_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) ();
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_dir;
    logic [CNT_W-1:0] cmd_count;
    logic             cmd_fill;

    modport master (
        output cmd_valid, cmd_data, cmd_dir, cmd_count, cmd_fill,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_data, cmd_dir, cmd_count, cmd_fill,
        output cmd_ready
    );
endinterface
`default_nettype wire

// File: rtl/shift_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : shift_cmd_fifo
//  Description : 2-entry command FIFO with synchronous active-high reset.
//                Push is ignored when full, pop is ignored when empty.
//  Ports       : clk, reset, i_push/i_push_data (write side),
//                i_pop/o_pop_data (read side, head shown combinationally),
//                o_full, o_empty
//  Revision    : 1.0  initial release
// ============================================================================
module shift_cmd_fifo #(
    parameter int DATA_W = 14
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              i_push,
    input  wire logic [DATA_W-1:0] i_push_data,
    input  wire logic              i_pop,
    output logic      [DATA_W-1:0] o_pop_data,
    output logic                   o_full,
    output logic                   o_empty
);
    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              w_push_ok;
    logic              w_pop_ok;

    assign o_full     = (cnt_q == 2'd2);
    assign o_empty    = (cnt_q == 2'd0);
    assign o_pop_data = mem_q[rd_ptr_q];
    assign w_push_ok  = i_push && !o_full;
    assign w_pop_ok   = i_pop && !o_empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + {1'b0, w_push_ok} - {1'b0, w_pop_ok};
        if (w_push_ok) begin
            mem_d[wr_ptr_q] = i_push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (w_pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/shift_reg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : shift_reg_sequencer
//  Description : Drives an 8-bit shift register with one parallel load followed
//                by N shift cycles per command, keeps a shadow copy of the
//                register and reports it with a one-cycle done pulse.
//  Ports       : clk, reset          clock, synchronous active-high reset
//                cmd (slave)         command handshake (valid/ready + fields)
//                sr_enable, sr_shift_dir, sr_data_in   registered register pins
//                busy, done, result  status and shadow result
//  Config      : SHIFT_REG_SEQ_QUEUE_EN - adds a 2-entry command FIFO so a new
//                command can start straight out of DONE.
//  Revision    : 1.0  initial release
// ============================================================================
module shift_reg_sequencer
    import shift_reg_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  wire logic             clk,
    input  wire logic             reset,
    shift_reg_sequencer_if.slave  cmd,
    output logic                  sr_enable,
    output logic [1:0]            sr_shift_dir,
    output logic [WIDTH-1:0]      sr_data_in,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      result
);
    localparam int CMD_W = WIDTH + CNT_W + 2;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              dir_q, dir_d;
    logic              fill_q, fill_d;
    logic [WIDTH-1:0]  shadow_q, shadow_d;
    logic              sr_enable_q, sr_enable_d;
    logic [1:0]        sr_shift_dir_q, sr_shift_dir_d;
    logic [WIDTH-1:0]  sr_data_in_q, sr_data_in_d;
    logic              done_q, done_d;
    logic [WIDTH-1:0]  result_q, result_d;

    logic              w_take;
    logic [CMD_W-1:0]  w_new_cmd;
    logic [WIDTH-1:0]  w_new_data;
    logic              w_new_dir;
    logic [CNT_W-1:0]  w_new_count;
    logic              w_new_fill;

`ifdef SHIFT_REG_SEQ_QUEUE_EN
    logic w_fifo_full;
    logic w_fifo_empty;

    assign cmd.cmd_ready = !w_fifo_full;
    // A queued command starts from IDLE or directly out of DONE.
    assign w_take = !w_fifo_empty && ((state_q == IDLE) || (state_q == DONE));

    shift_cmd_fifo #(
        .DATA_W (CMD_W)
    ) u_cmd_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (cmd.cmd_valid),
        .i_push_data ({cmd.cmd_data, cmd.cmd_dir, cmd.cmd_count, cmd.cmd_fill}),
        .i_pop       (w_take),
        .o_pop_data  (w_new_cmd),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );
`else
    assign cmd.cmd_ready = (state_q == IDLE);
    assign w_take        = cmd.cmd_valid && (state_q == IDLE);
    assign w_new_cmd     = {cmd.cmd_data, cmd.cmd_dir, cmd.cmd_count, cmd.cmd_fill};
`endif

    assign w_new_data  = w_new_cmd[CMD_W-1 -: WIDTH];
    assign w_new_dir   = w_new_cmd[CNT_W+1];
    assign w_new_count = w_new_cmd[CNT_W:1];
    assign w_new_fill  = w_new_cmd[0];

    // Next state and command registers
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dir_d   = dir_q;
        fill_d  = fill_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (w_take) begin
                    state_d = LOAD;
                    count_d = w_new_count;
                    dir_d   = w_new_dir;
                    fill_d  = w_new_fill;
                end
            end
            LOAD: begin
                state_d = (count_q == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                count_d = count_q - 1'b1;
                if (count_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The sr_* pins are registered from the next state so they are valid for
    // the whole cycle the FSM spends in LOAD/SHIFT; the register acts at its end.
    // The shadow follows the register by applying the pins on the same edge.
    always_comb begin
        sr_enable_d    = (state_d == LOAD) || (state_d == SHIFT);
        sr_shift_dir_d = SR_SHL;
        sr_data_in_d   = '0;
        if (state_d == LOAD) begin
            sr_shift_dir_d = SR_LOAD;
            sr_data_in_d   = w_new_data;
        end else if (state_d == SHIFT) begin
            sr_shift_dir_d = dir_d ? SR_SHR : SR_SHL;
            sr_data_in_d   = {WIDTH{fill_d}};
        end

        shadow_d = shadow_q;
        if (sr_enable_q) begin
            case (sr_shift_dir_q)
                SR_LOAD: shadow_d = sr_data_in_q;
                SR_SHR:  shadow_d = {sr_data_in_q[WIDTH-1], shadow_q[WIDTH-1:1]};
                default: shadow_d = {shadow_q[WIDTH-2:0], sr_data_in_q[0]};
            endcase
        end

        done_d   = (state_d == DONE);
        result_d = done_d ? shadow_d : result_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            count_q        <= '0;
            dir_q          <= 1'b0;
            fill_q         <= 1'b0;
            shadow_q       <= '0;
            sr_enable_q    <= 1'b0;
            sr_shift_dir_q <= SR_SHL;
            sr_data_in_q   <= '0;
            done_q         <= 1'b0;
            result_q       <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            dir_q          <= dir_d;
            fill_q         <= fill_d;
            shadow_q       <= shadow_d;
            sr_enable_q    <= sr_enable_d;
            sr_shift_dir_q <= sr_shift_dir_d;
            sr_data_in_q   <= sr_data_in_d;
            done_q         <= done_d;
            result_q       <= result_d;
        end
    end

    assign sr_enable    = sr_enable_q;
    assign sr_shift_dir = sr_shift_dir_q;
    assign sr_data_in   = sr_data_in_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign result       = result_q;
endmodule
`default_nettype wire
